// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, monitor state type and saturating helpers
// for the VGA timing monitor.
package vga_timing_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } mon_state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == '1) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Strobe-qualified sync history register with a falling-edge pulse output.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic sync,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
    end else if (stb) begin
      prev <= sync;
    end
  end

  assign fall = stb & prev & ~sync;

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers pixel position from strobe-sampled HS/VS and verifies 640x480@60 timing.
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_LEN   = H_TOTAL,
  parameter int unsigned H_START = H_SYNC + H_BP,
  parameter int unsigned H_ACT   = H_ACTIVE,
  parameter int unsigned V_LEN   = V_TOTAL,
  parameter int unsigned V_START = V_SYNC + V_BP,
  parameter int unsigned V_ACT   = V_ACTIVE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_err,
  output logic [10:0] o_h_total,
  output logic [9:0]  o_v_total
);

  logic        hs_fall, vs_fall;
  logic        pending;
  logic        line_start, frame_start;
  logic [10:0] hcnt, hcnt_next, h_len;
  logic [9:0]  vcnt, vcnt_next, v_len;
  logic        h_bad, v_bad, vis;
  logic        err_next;
  mon_state_t  state, state_next;

  vga_sync_edge u_hs_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .stb  (i_pix_stb),
    .sync (i_hs),
    .fall (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .stb  (i_pix_stb),
    .sync (i_vs),
    .fall (vs_fall)
  );

  // A VS fall is deferred until the next HS fall so the frame always starts on a line boundary.
  assign line_start  = hs_fall;
  assign frame_start = hs_fall & (vs_fall | pending);

  always_comb begin
    h_len     = sat_inc11(hcnt);
    v_len     = sat_inc10(vcnt);
    hcnt_next = hcnt;
    vcnt_next = vcnt;
    if (i_pix_stb) begin
      hcnt_next = line_start ? '0 : h_len;
      if (frame_start) begin
        vcnt_next = '0;
      end else if (line_start) begin
        vcnt_next = v_len;
      end
    end
    h_bad = line_start && (h_len != 11'(H_LEN));
    v_bad = frame_start && (v_len != 10'(V_LEN));
    vis   = (hcnt_next >= 11'(H_START)) && (hcnt_next < 11'(H_START + H_ACT)) &&
            (vcnt_next >= 10'(V_START)) && (vcnt_next < 10'(V_START + V_ACT));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SEARCH;
      o_err <= 1'b0;
    end else begin
      state <= state_next;
      o_err <= err_next;
    end
  end

  // Line-length mismatch wins over a coincident frame start and yields a single error.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      SEARCH: begin
        if (frame_start) state_next = CHECK;
      end
      CHECK: begin
        if (h_bad) begin
          err_next   = 1'b1;
          state_next = SEARCH;
        end else if (frame_start) begin
          if (v_bad) err_next = 1'b1;
          else       state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad) begin
          err_next   = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    o_locked = (state == LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      pending   <= 1'b0;
      o_h_total <= '0;
      o_v_total <= '0;
      o_x       <= '0;
      o_y       <= '0;
      o_active  <= 1'b0;
    end else if (i_pix_stb) begin
      hcnt    <= hcnt_next;
      vcnt    <= vcnt_next;
      pending <= line_start ? 1'b0 : (pending | vs_fall);
      if (line_start)  o_h_total <= h_len;
      if (frame_start) o_v_total <= v_len;
      o_x      <= vis ? 10'(hcnt_next - 11'(H_START)) : '0;
      o_y      <= vis ? 9'(vcnt_next - 10'(V_START)) : '0;
      o_active <= vis && (state_next == LOCKED);
    end
  end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 SHALL have port i_clk, input, 1, system clock (100 MHz); sole clock.
REQ-002 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port i_pix_stb, input, 1, pixel strobe (one i_clk cycle per pixel, 25 MHz rate).
REQ-004 SHALL have port i_hs, input, 1, horizontal sync, active-low, synchronous to i_clk.
REQ-005 SHALL have port i_vs, input, 1, vertical sync, active-low, synchronous to i_clk.
REQ-006 SHALL have port o_x, output, 10, recovered pixel column (0-639).
REQ-007 SHALL have port o_y, output, 9, recovered pixel row (0-479).
REQ-008 SHALL have port o_active, output, 1, high while locked and inside the 640x480 visible area.
REQ-009 SHALL have port o_locked, output, 1, input timing verified as 640x480@60.
REQ-010 SHALL have port o_err, output, 1, one-cycle pulse on any timing mismatch.
REQ-011 SHALL have port o_h_total, output, 11, pixel count of the last complete line.
REQ-012 SHALL have port o_v_total, output, 10, line count of the last complete frame.

Function
REQ-013 SHALL sample i_hs/i_vs only on cycles with i_pix_stb high; all state SHALL hold when i_pix_stb is low.
REQ-014 SHALL detect a line start as an i_hs 1->0 transition between consecutive strobe samples.
REQ-015 SHALL detect a frame start as an i_vs 1->0 transition; the transition SHALL be held pending and take effect at the next line start, or at the same strobe if both fall together.
REQ-016 hcnt (11 bit) SHALL clear to 0 at each line start, increment per strobe otherwise, and saturate at 2047.
REQ-017 vcnt (10 bit) SHALL clear to 0 at the line start that takes the frame start, increment at other line starts, and saturate at 1023.
REQ-018 At each line start, o_h_total SHALL load the pre-clear hcnt+1; at each frame start, o_v_total SHALL load the pre-clear vcnt+1.
REQ-019 The visible area SHALL be 144<=hcnt<784 and 35<=vcnt<515; o_x=hcnt-144 and o_y=vcnt-35 inside it, both 0 outside it.
REQ-020 o_x, o_y and o_active SHALL be registered and update one i_clk after the sampling strobe.
REQ-021 SHALL implement states SEARCH, CHECK and LOCKED.
REQ-022 SEARCH: first frame start -> CHECK; no length checks.
REQ-023 CHECK: any line length !=800 -> o_err, SEARCH; frame start with frame length ==525 -> LOCKED; !=525 -> o_err, stay in CHECK (new frame).
REQ-024 LOCKED: line length !=800 or frame length !=525 -> o_err, SEARCH in the same cycle, o_locked low the next cycle.
REQ-025 o_locked SHALL be high exactly in LOCKED; o_active SHALL be forced low outside LOCKED.
REQ-026 A mismatch and a frame start on the same strobe SHALL give a single o_err pulse, and the mismatch SHALL take priority.

Reset
REQ-027 While i_rst is high, SHALL set state SEARCH, hcnt=vcnt=0, pending flag clear, sync history =1, and all outputs 0.
REQ-028 A reset asserted mid-frame SHALL abandon the frame; relock SHALL require a fresh SEARCH->CHECK->LOCKED sequence.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the H_TOTAL=800, H_SYNC=96, H_BP=48, H_ACTIVE=640, V_TOTAL=525, V_SYNC=2, V_BP=33 and V_ACTIVE=480 constants and the state enum.
REQ-030 SHALL contain one sub-module, vga_sync_edge, that registers a strobe-qualified sync and outputs a falling-edge pulse; it SHALL be instantiated twice.
REQ-031 Target size: 120-400 RTL lines; no memories.

Verification
REQ-032 Drive the DUT from a vga640x480 generator on the same strobe -> o_locked rises at the second frame start; thereafter o_x/o_y equal the generator x/y (one clk later) whenever o_active is high.
REQ-033 Shorten one line to 799 pixels while locked -> one o_err pulse, o_h_total=799, o_locked low, relock after two clean frames.
REQ-034 Send a 524-line frame while in CHECK -> o_err, o_v_total=524, no lock; the next 525-line frame -> o_locked.
REQ-035 Assert i_rst for one cycle mid-frame while locked -> all outputs 0 the next cycle, with relock at the second subsequent frame start.
REQ-036 Hold i_pix_stb low for 1000 cycles while toggling i_hs -> no change to any output or counter.
REQ-037 Hold i_hs high for 3000 strobes -> hcnt saturates at 2047; the next line start reports o_h_total=2048 capped to 2047 and gives o_err.
